pipeline_swap_sequencer: RTL and testbench
==========================================

Name: pipeline_swap_sequencer

Overview:
Sequences the A/B pipeline handover for the DSP engine. On a swap request from the control unit, it crossfades the mixer weight from the current pipeline to the standby pipeline over a programmable number of samples. It then commits the swap, flips current_pipeline, and holds the now-standby pipeline in reset. It sits between control_unit_seq and the mixer, replacing the ad-hoc swap handling in the mixer.

Parameters:
coef_width, 8, crossfade fraction bits; FULL = 2^coef_width
reset_cycles, 4, cycles the retired pipeline's reset is held (min 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
swap_req  in  1  1-cycle pulse from control unit requesting a swap
fade_step  in  coef_width+1  coefficient increment per sample, latched on accepted swap_req; 0 = hard swap
sample_tick  in  1  1-cycle pulse when the engine starts processing a new sample (pipeline_tick)
current_pipeline  out  1  index of the pipeline weighted (FULL-coef)
fade_coef  out  coef_width+1  weight of the non-current pipeline, 0..FULL
pipelines_swapping  out  1  high from accepted swap_req until the reset hold ends
reset_pipeline  out  2  per-pipeline reset by absolute index (bit0 = A, bit1 = B)
swap_done  out  1  1-cycle pulse on commit
swap_rejected  out  1  1-cycle pulse when swap_req arrives while busy

Behaviour:
- Reset values (async, reset low): state IDLE, current_pipeline 0, fade_coef 0, pipelines_swapping 0, reset_pipeline 2'b00, swap_done 0, swap_rejected 0, step register 0, hold counter 0.
- Mixer contract: out = (cur*(FULL-coef) + other*coef) >> coef_width. At commit, current_pipeline flips and coef goes FULL->0 in the same cycle, so the output is sample-identical across commit.
- fade_coef and current_pipeline change only in the cycle after a sample_tick. They stay stable for the whole processing/mixing window of a sample.
- IDLE:
  - On swap_req: latch fade_step, set pipelines_swapping=1, go FADING. The next cycle's registered outputs are unchanged.
  - sample_tick in the same cycle as swap_req is not consumed by the fade.
- FADING, on sample_tick:
  - If step==0 or coef==FULL: COMMIT.
  - Else coef <= min(coef+step, FULL), saturating. Compute in coef_width+2 bits; no wrap.
- COMMIT (same edge as the deciding tick):
  - current_pipeline toggles and coef <= 0.
  - swap_done pulses.
  - reset_pipeline bit of the old current index asserts. Load the hold counter with reset_cycles-1 and go RESETTING.
- RESETTING:
  - Decrement the counter each cycle. At 0, deassert reset_pipeline, drop pipelines_swapping, go IDLE.
  - sample_ticks here are ignored; the retired pipeline has weight 0.
- Latency: a swap with step s takes ceil(FULL/s)+1 sample_ticks from acceptance to commit. Hard swap (s=0) commits on the first tick.
- swap_req while state != IDLE: ignored; pulse swap_rejected next cycle. The latched step is unchanged.
- swap_req coincident with the final RESETTING cycle: rejected.
- No sample_tick ever arriving: remains in FADING indefinitely (no timeout). pipelines_swapping stays high, so the control unit must not write the standby pipeline.
- Async reset mid-fade or mid-hold: immediate return to reset values; reset_pipeline drops asynchronously.

Decomposition:
- engine.vh gains `SWAP_STATE_IDLE/FADING/RESETTING` (2-bit encodings) and `SWAP_COEF_WIDTH` default.
- Single flat module; the saturating add is inline. No sub-module is warranted.

Test Plan:
- Reset, then 3 sample_ticks with no request -> current_pipeline 0, fade_coef 0, reset_pipeline 00, pipelines_swapping 0 throughout.
- swap_req with fade_step=64 (coef_width 8):
  - Ticks 1-4 -> coef 64, 128, 192, 256.
  - Tick 5 -> current_pipeline 1, coef 0, swap_done pulse, reset_pipeline=01 for exactly 4 cycles, then pipelines_swapping 0.
- fade_step=100 -> coef 100, 200, 256 (saturated, no wrap to 44); 4th tick commits.
- fade_step=0 with current_pipeline=1 -> first tick: current_pipeline 0, reset_pipeline=10, swap_done; coef stays 0.
- Second swap_req during FADING -> swap_rejected 1-cycle pulse; the fade continues with the original step and commits on schedule.
- Assert reset low during FADING at coef=128 -> all outputs return to reset values asynchronously. After release, a new swap_req is accepted normally.

Source files
------------

// File: rtl/pipeline_swap_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_swap_sequencer_pkg : shared state encoding and defaults for the
// A/B pipeline swap sequencer.   Rev 1.0
// ---------------------------------------------------------------------------
package pipeline_swap_sequencer_pkg;

  localparam int SWAP_COEF_WIDTH   = 8;
  localparam int SWAP_RESET_CYCLES = 4;

  typedef enum logic [1:0] {
    SWAP_IDLE      = 2'd0,
    SWAP_FADING    = 2'd1,
    SWAP_RESETTING = 2'd2
  } swap_state_e;

endpackage : pipeline_swap_sequencer_pkg
`default_nettype wire

// File: rtl/pipeline_swap_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_swap_sequencer : crossfades the mixer from the current to the
// standby pipeline, commits the swap, then holds the retired one in reset.
// Rev 1.0
// ---------------------------------------------------------------------------
module pipeline_swap_sequencer
  import pipeline_swap_sequencer_pkg::*;
#(
  parameter int COEF_WIDTH   = SWAP_COEF_WIDTH,
  parameter int RESET_CYCLES = SWAP_RESET_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  swap_req_i,
  input  logic [COEF_WIDTH:0]   fade_step_i,
  input  logic                  sample_tick_i,
  output logic                  current_pipeline_o,
  output logic [COEF_WIDTH:0]   fade_coef_o,
  output logic                  pipelines_swapping_o,
  output logic [1:0]            reset_pipeline_o,
  output logic                  swap_done_o,
  output logic                  swap_rejected_o
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [COEF_WIDTH:0] FULL = {1'b1, {COEF_WIDTH{1'b0}}};

  swap_state_e            state_q, state_d;
  logic                   cur_q, cur_d;
  logic [COEF_WIDTH:0]    coef_q, coef_d;
  logic [COEF_WIDTH:0]    step_q, step_d;
  logic                   swapping_q, swapping_d;
  logic [1:0]             rstp_q, rstp_d;
  logic                   done_q, done_d;
  logic                   rej_q, rej_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [COEF_WIDTH+1:0]  sum;

  // One extra bit keeps the saturating add from wrapping.
  assign sum = {1'b0, coef_q} + {1'b0, step_q};

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    coef_d     = coef_q;
    step_d     = step_q;
    swapping_d = swapping_q;
    rstp_d     = rstp_q;
    done_d     = 1'b0;
    rej_d      = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      SWAP_IDLE: begin
        if (swap_req_i) begin
          step_d     = fade_step_i;
          swapping_d = 1'b1;
          state_d    = SWAP_FADING;
        end
      end
      SWAP_FADING: begin
        rej_d = swap_req_i;
        if (sample_tick_i) begin
          if ((step_q == '0) || (coef_q == FULL)) begin
            // Flip and zero together so the mixed output is continuous.
            cur_d   = ~cur_q;
            coef_d  = '0;
            done_d  = 1'b1;
            rstp_d  = cur_q ? 2'b10 : 2'b01;
            cnt_d   = CNT_W'(RESET_CYCLES - 1);
            state_d = SWAP_RESETTING;
          end else if (sum > {1'b0, FULL}) begin
            coef_d = FULL;
          end else begin
            coef_d = sum[COEF_WIDTH:0];
          end
        end
      end
      SWAP_RESETTING: begin
        rej_d = swap_req_i;
        if (cnt_q == '0) begin
          rstp_d     = 2'b00;
          swapping_d = 1'b0;
          state_d    = SWAP_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SWAP_IDLE;
      cur_q      <= 1'b0;
      coef_q     <= '0;
      step_q     <= '0;
      swapping_q <= 1'b0;
      rstp_q     <= 2'b00;
      done_q     <= 1'b0;
      rej_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      coef_q     <= coef_d;
      step_q     <= step_d;
      swapping_q <= swapping_d;
      rstp_q     <= rstp_d;
      done_q     <= done_d;
      rej_q      <= rej_d;
      cnt_q      <= cnt_d;
    end
  end

  assign current_pipeline_o   = cur_q;
  assign fade_coef_o          = coef_q;
  assign pipelines_swapping_o = swapping_q;
  assign reset_pipeline_o     = rstp_q;
  assign swap_done_o          = done_q;
  assign swap_rejected_o      = rej_q;

endmodule : pipeline_swap_sequencer
`default_nettype wire

// File: tb/tb_pipeline_swap_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeline_swap_sequencer : directed self-checking bench for the swap
// sequencer with hand-computed expected values.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipeline_swap_sequencer;

  logic       clk;
  logic       rst_n;
  logic       swap_req;
  logic [8:0] fade_step;
  logic       sample_tick;
  logic       cur;
  logic [8:0] coef;
  logic       swapping;
  logic [1:0] rstp;
  logic       done;
  logic       rej;

  int n_chk  = 0;
  int n_pass = 0;

  pipeline_swap_sequencer #(
    .COEF_WIDTH   (8),
    .RESET_CYCLES (4)
  ) u_dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .swap_req_i           (swap_req),
    .fade_step_i          (fade_step),
    .sample_tick_i        (sample_tick),
    .current_pipeline_o   (cur),
    .fade_coef_o          (coef),
    .pipelines_swapping_o (swapping),
    .reset_pipeline_o     (rstp),
    .swap_done_o          (done),
    .swap_rejected_o      (rej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_out(input string tag, input int e_cur, input int e_coef,
                         input int e_swp, input int e_rstp, input int e_done,
                         input int e_rej);
    chk({tag, ".cur"},  32'(cur),      e_cur);
    chk({tag, ".coef"}, 32'(coef),     e_coef);
    chk({tag, ".swp"},  32'(swapping), e_swp);
    chk({tag, ".rstp"}, 32'(rstp),     e_rstp);
    chk({tag, ".done"}, 32'(done),     e_done);
    chk({tag, ".rej"},  32'(rej),      e_rej);
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic cyc(input logic req, input logic tick, input logic [8:0] step);
    swap_req    = req;
    sample_tick = tick;
    fade_step   = step;
    @(posedge clk);
    #1;
    swap_req    = 1'b0;
    sample_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; swap_req = 1'b0; sample_tick = 1'b0; fade_step = '0;
    #12;
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 9'd0);
      chk_out("idle_tick", 0, 0, 0, 0, 0, 0);
    end

    // Step 64: four ramp ticks, commit on the fifth.
    cyc(1'b1, 1'b0, 9'd64);
    chk_out("acc64", 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b1, 9'd0);
      chk_out("ramp64", 0, 64 * k, 1, 0, 0, 0);
      cyc(1'b0, 1'b0, 9'd0);
      chk("hold64.coef", 32'(coef), 64 * k);
    end
    cyc(1'b0, 1'b1, 9'd0);
    chk_out("commit64", 1, 0, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 9'd0);
      chk_out("hold_rst64", 1, 0, 1, 1, 0, 0);
    end
    cyc(1'b0, 1'b0, 9'd0);
    chk_out("release64", 1, 0, 0, 0, 0, 0);

    // Hard swap from pipeline 1; coincident tick must not be consumed.
    cyc(1'b1, 1'b1, 9'd0);
    chk_out("acc0", 1, 0, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 9'd0);
    chk_out("commit0", 0, 0, 1, 2, 1, 0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 9'd0);
    chk_out("release0", 0, 0, 0, 0, 0, 0);

    // Step 100 saturates at 256 rather than wrapping to 44.
    cyc(1'b1, 1'b0, 9'd100);
    cyc(1'b0, 1'b1, 9'd0);
    chk("sat.t1", 32'(coef), 100);
    cyc(1'b0, 1'b1, 9'd0);
    chk("sat.t2", 32'(coef), 200);
    cyc(1'b0, 1'b1, 9'd0);
    chk("sat.t3", 32'(coef), 256);
    cyc(1'b0, 1'b1, 9'd0);
    chk_out("commit100", 1, 0, 1, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 9'd0);
    chk_out("release100", 1, 0, 0, 0, 0, 0);

    // Rejection during FADING keeps the original step.
    cyc(1'b1, 1'b0, 9'd128);
    cyc(1'b0, 1'b1, 9'd0);
    chk("rj.t1", 32'(coef), 128);
    cyc(1'b1, 1'b0, 9'd0);
    chk_out("rj.pulse", 1, 128, 1, 0, 0, 1);
    cyc(1'b0, 1'b0, 9'd0);
    chk("rj.clear", 32'(rej), 0);
    cyc(1'b0, 1'b1, 9'd0);
    chk_out("rj.t2", 1, 256, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 9'd0);
    chk_out("rj.commit", 0, 0, 1, 2, 1, 0);
    cyc(1'b0, 1'b0, 9'd0);
    cyc(1'b0, 1'b0, 9'd0);
    cyc(1'b0, 1'b0, 9'd0);
    chk("rj.last_hold", 32'(rstp), 2);
    cyc(1'b1, 1'b0, 9'd64);
    chk_out("rj.final_cycle", 0, 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 9'd0);
    chk("rj.still_idle", 32'(swapping), 0);

    // Asynchronous reset mid-fade.
    cyc(1'b1, 1'b0, 9'd64);
    cyc(1'b0, 1'b1, 9'd0);
    cyc(1'b0, 1'b1, 9'd0);
    chk("ar.coef", 32'(coef), 128);
    #2 rst_n = 1'b0;
    #1;
    chk_out("ar.async", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 9'd32);
    chk_out("ar.accept", 0, 0, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 9'd0);
    chk("ar.t1", 32'(coef), 32);

    // Asynchronous reset mid-hold drops reset_pipeline without a clock.
    cyc(1'b1, 1'b0, 9'd0);
    chk("mh.rej", 32'(rej), 1);
    swap_req = 1'b0;
    fade_step = 9'd0;
    cyc(1'b0, 1'b0, 9'd0);
    cyc(1'b0, 1'b0, 9'd0);
    cyc(1'b0, 1'b0, 9'd0);
    cyc(1'b0, 1'b1, 9'd0);
    chk("mh.t2", 32'(coef), 64);
    rst_n = 1'b0;
    #1;
    chk_out("mh.async", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 9'd0);
    cyc(1'b0, 1'b1, 9'd0);
    chk_out("mh.hard", 1, 0, 1, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("mh.hold_async", 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pipeline_swap_sequencer
`default_nettype wire
